// File: rtl/z80_io_mailbox.sv
// Z80 I/O mailbox bridge: NUM_CH byte channels each way, status ports
// and ROM-shadow paging, with Z80 strobes synchronised into clk.
module z80_io_mailbox #(
   parameter int          NUM_CH        = 8,
   parameter logic [15:0] IO_BASE       = 16'd12345,
   parameter int          IO_STRIDE     = 2,
   parameter logic [15:0] IO_MASK       = 16'hFFFF,
   parameter logic [15:0] IO_STAT_H2Z   = 16'd12339,
   parameter logic [15:0] IO_STAT_Z2H   = 16'd12341,
   parameter logic [15:0] IO_MAP_SHADOW = 16'd12343,
   parameter logic [15:0] TRAP_ADDR     = 16'h0000,
   parameter bit          TRAP_EN       = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           z80_a,
   inout  wire  [7:0]            z80_d,
   input  logic                  z80_rd,
   input  logic                  z80_wr,
   input  logic                  z80_m1,
   input  logic                  z80_iorq,
   input  logic                  z80_mreq,
   output logic                  z80_d_dir,
   output logic                  z80_romcs,
   input  logic [8*NUM_CH-1:0]   h2z_data_flat,
   input  logic [NUM_CH-1:0]     h2z_load,
   output logic [NUM_CH-1:0]     h2z_full,
   output logic [NUM_CH-1:0]     h2z_overrun,
   output logic [8*NUM_CH-1:0]   z2h_data_flat,
   output logic [NUM_CH-1:0]     z2h_valid,
   input  logic [NUM_CH-1:0]     z2h_ack,
   output logic [NUM_CH-1:0]     z2h_overrun
);

   typedef enum logic {
      ROM_ON,
      ROM_OFF
   } shadow_e;

   function automatic logic match(
      input logic [15:0] a,
      input logic [15:0] p
   );
      return (a & IO_MASK) == (p & IO_MASK);
   endfunction

   function automatic logic [NUM_CH-1:0] ch_hit(
      input logic [15:0] a
   );
      logic [NUM_CH-1:0] h;
      h = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         h[i] = match(a, IO_BASE + 16'(IO_STRIDE * i));
      end
      return h;
   endfunction

   logic [7:0]        r_h2z_data [NUM_CH];
   logic [7:0]        r_z2h_data [NUM_CH];
   logic [NUM_CH-1:0] r_h2z_full;
   logic [NUM_CH-1:0] r_h2z_ovr;
   logic [NUM_CH-1:0] r_z2h_valid;
   logic [NUM_CH-1:0] r_z2h_ovr;

   logic [15:0] r_a_s1, r_a_s2, r_a_s3;
   logic [7:0]  r_d_s1, r_d_s2;
   logic        r_rd_s1, r_rd_s2, r_rd_s3;
   logic        r_wr_s1, r_wr_s2, r_wr_s3;
   logic        r_iorq_s1, r_iorq_s2, r_iorq_s3;
   logic        r_m1_s1, r_m1_s2, r_m1_s3;
   logic        r_mreq_s1, r_mreq_s2;

   shadow_e     r_state;
   logic        r_romcs;

   logic              w_io_raw;
   logic [NUM_CH-1:0] w_ch_raw;
   logic              w_sh_raw;
   logic              w_sz_raw;
   logic              w_rd_act;
   logic [7:0]        w_rdata;

   logic              w_wr_fall;
   logic              w_rd_rise;
   logic              w_rd_fall;
   logic              w_io_s2;
   logic              w_io_s3;
   logic [NUM_CH-1:0] w_wr_ch;
   logic [NUM_CH-1:0] w_rd_ch;
   logic              w_map_out;
   logic              w_map_in;
   logic              w_trap;

   // Bus read path works straight off the pins so the Z80 sees data in-cycle
   assign w_io_raw = ~z80_iorq & z80_m1;
   assign w_ch_raw = w_io_raw ? ch_hit(z80_a) : '0;
   assign w_sh_raw = w_io_raw & match(z80_a, IO_STAT_H2Z);
   assign w_sz_raw = w_io_raw & match(z80_a, IO_STAT_Z2H);
   assign w_rd_act = ~z80_rd & z80_wr
                   & ((|w_ch_raw) | w_sh_raw | w_sz_raw);

   always_comb begin
      w_rdata = '0;
      if (w_sh_raw) begin
         w_rdata[NUM_CH-1:0] = r_h2z_full;
      end else if (w_sz_raw) begin
         w_rdata[NUM_CH-1:0] = r_z2h_valid;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_raw[i]) begin
               w_rdata = r_h2z_data[i];
            end
         end
      end
   end

   assign z80_d     = w_rd_act ? w_rdata : 8'bz;
   assign z80_d_dir = ~w_rd_act;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_s1    <= '0;
         r_a_s2    <= '0;
         r_a_s3    <= '0;
         r_d_s1    <= '0;
         r_d_s2    <= '0;
         r_rd_s1   <= 1'b1;
         r_rd_s2   <= 1'b1;
         r_rd_s3   <= 1'b1;
         r_wr_s1   <= 1'b1;
         r_wr_s2   <= 1'b1;
         r_wr_s3   <= 1'b1;
         r_iorq_s1 <= 1'b1;
         r_iorq_s2 <= 1'b1;
         r_iorq_s3 <= 1'b1;
         r_m1_s1   <= 1'b1;
         r_m1_s2   <= 1'b1;
         r_m1_s3   <= 1'b1;
         r_mreq_s1 <= 1'b1;
         r_mreq_s2 <= 1'b1;
      end else begin
         r_a_s1    <= z80_a;
         r_a_s2    <= r_a_s1;
         r_a_s3    <= r_a_s2;
         r_d_s1    <= z80_d;
         r_d_s2    <= r_d_s1;
         r_rd_s1   <= z80_rd;
         r_rd_s2   <= r_rd_s1;
         r_rd_s3   <= r_rd_s2;
         r_wr_s1   <= z80_wr;
         r_wr_s2   <= r_wr_s1;
         r_wr_s3   <= r_wr_s2;
         r_iorq_s1 <= z80_iorq;
         r_iorq_s2 <= r_iorq_s1;
         r_iorq_s3 <= r_iorq_s2;
         r_m1_s1   <= z80_m1;
         r_m1_s2   <= r_m1_s1;
         r_m1_s3   <= r_m1_s2;
         r_mreq_s1 <= z80_mreq;
         r_mreq_s2 <= r_mreq_s1;
      end
   end

   assign w_wr_fall = r_wr_s3 & ~r_wr_s2;
   assign w_rd_rise = ~r_rd_s3 & r_rd_s2;
   assign w_rd_fall = r_rd_s3 & ~r_rd_s2;
   assign w_io_s2   = ~r_iorq_s2 & r_m1_s2;
   // IORQ lifts together with RD, so read-end decode uses the prior sample
   assign w_io_s3   = ~r_iorq_s3 & r_m1_s3;

   assign w_wr_ch   = (w_wr_fall & w_io_s2) ? ch_hit(r_a_s2) : '0;
   assign w_rd_ch   = (w_rd_rise & w_io_s3) ? ch_hit(r_a_s3) : '0;
   assign w_map_out = w_wr_fall & w_io_s2
                    & match(r_a_s2, IO_MAP_SHADOW);
   assign w_map_in  = w_rd_rise & w_io_s3
                    & match(r_a_s3, IO_MAP_SHADOW);
   assign w_trap    = TRAP_EN & w_rd_fall
                    & ~r_m1_s2 & ~r_mreq_s2
                    & (r_a_s2 == TRAP_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h2z_full  <= '0;
         r_h2z_ovr   <= '0;
         r_z2h_valid <= '0;
         r_z2h_ovr   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_h2z_data[i] <= '0;
            r_z2h_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_rd_ch[i]) begin
               r_h2z_full[i] <= 1'b0;
            end
            if (h2z_load[i]) begin
               r_h2z_data[i] <= h2z_data_flat[8*i +: 8];
               r_h2z_full[i] <= 1'b1;
               if (r_h2z_full[i]) begin
                  r_h2z_ovr[i] <= 1'b1;
               end
            end
            if (z2h_ack[i]) begin
               r_z2h_valid[i] <= 1'b0;
               r_z2h_ovr[i]   <= 1'b0;
            end
            // A write racing the ack takes the slot without an overrun
            if (w_wr_ch[i]) begin
               r_z2h_data[i]  <= r_d_s2;
               r_z2h_valid[i] <= 1'b1;
               if (r_z2h_valid[i] & ~z2h_ack[i]) begin
                  r_z2h_ovr[i] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ROM_ON;
         r_romcs <= 1'b1;
      end else begin
         unique case (r_state)
            ROM_ON: begin
               if (w_trap | w_map_in) begin
                  r_state <= ROM_OFF;
                  r_romcs <= 1'b0;
               end
            end
            ROM_OFF: begin
               if (w_map_out) begin
                  r_state <= ROM_ON;
                  r_romcs <= 1'b1;
               end
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
      assign z2h_data_flat[8*g +: 8] = r_z2h_data[g];
   end

   assign h2z_full    = r_h2z_full;
   assign h2z_overrun = r_h2z_ovr;
   assign z2h_valid   = r_z2h_valid;
   assign z2h_overrun = r_z2h_ovr;
   assign z80_romcs   = r_romcs;

endmodule

// File: tb/tb_z80_io_mailbox.sv
// Randomised bench for z80_io_mailbox against a transaction-level
// model of mailbox flags, data and ROM paging.
module tb_z80_io_mailbox;

   localparam logic [15:0] BASE = 16'd12345;
   localparam logic [15:0] STH  = 16'd12339;
   localparam logic [15:0] STZ  = 16'd12341;
   localparam logic [15:0] MAP  = 16'd12343;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] a = '0;
   wire  [7:0]  z80_d;
   logic [7:0]  tb_d = '0;
   logic        tb_den = 1'b0;
   logic        rd = 1'b1, wr = 1'b1, m1 = 1'b1;
   logic        iorq = 1'b1, mreq = 1'b1;
   logic        d_dir, romcs;
   logic [63:0] h2z_flat = '0;
   logic [7:0]  load = '0, ack = '0;
   logic [7:0]  full, hov, valid, zov;
   logic [63:0] z2h_flat;

   assign z80_d = tb_den ? tb_d : 8'bz;

   always #5 clk = ~clk;

   z80_io_mailbox dut (
      .clk(clk), .rst(rst), .z80_a(a), .z80_d(z80_d),
      .z80_rd(rd), .z80_wr(wr), .z80_m1(m1),
      .z80_iorq(iorq), .z80_mreq(mreq),
      .z80_d_dir(d_dir), .z80_romcs(romcs),
      .h2z_data_flat(h2z_flat), .h2z_load(load),
      .h2z_full(full), .h2z_overrun(hov),
      .z2h_data_flat(z2h_flat), .z2h_valid(valid),
      .z2h_ack(ack), .z2h_overrun(zov)
   );

   // Reference model: per-channel mailbox slots
   logic [7:0] m_h2z [8];
   logic [7:0] m_z2h [8];
   logic [7:0] m_full, m_hov, m_valid, m_zov;
   logic       m_romcs;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic m_reset();
      for (int i = 0; i < 8; i++) begin
         m_h2z[i] = '0;
         m_z2h[i] = '0;
      end
      m_full = '0; m_hov = '0;
      m_valid = '0; m_zov = '0;
      m_romcs = 1'b1;
   endtask

   task automatic check_all(input string tag);
      logic [63:0] e;
      for (int i = 0; i < 8; i++) e[8*i +: 8] = m_z2h[i];
      chk({tag, ".full"},  64'(full),  64'(m_full));
      chk({tag, ".hov"},   64'(hov),   64'(m_hov));
      chk({tag, ".valid"}, 64'(valid), 64'(m_valid));
      chk({tag, ".zov"},   64'(zov),   64'(m_zov));
      chk({tag, ".romcs"}, 64'(romcs), 64'(m_romcs));
      chk({tag, ".zdata"}, z2h_flat, e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   task automatic wr_start(input logic [15:0] ad, input logic [7:0] d);
      @(negedge clk);
      a = ad; tb_d = d; tb_den = 1'b1; iorq = 1'b0;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic wr_end();
      @(negedge clk);
      wr = 1'b1; iorq = 1'b1;
      @(negedge clk);
      tb_den = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic z80_out(input logic [15:0] ad, input logic [7:0] d);
      wr_start(ad, d);
      repeat (4) @(posedge clk);
      wr_end();
   endtask

   task automatic in_start(input logic [15:0] ad,
                           output logic [7:0] d,
                           output logic dir);
      @(negedge clk);
      a = ad; iorq = 1'b0; rd = 1'b0;
      @(negedge clk);
      d = z80_d;
      dir = d_dir;
   endtask

   task automatic z80_in(input logic [15:0] ad,
                         output logic [7:0] d,
                         output logic dir);
      in_start(ad, d, dir);
      rd = 1'b1; iorq = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic host_load(input int ch, input logic [7:0] d);
      @(negedge clk);
      h2z_flat[8*ch +: 8] = d;
      load[ch] = 1'b1;
      @(negedge clk);
      load = '0;
      if (m_full[ch]) m_hov[ch] = 1'b1;
      m_full[ch] = 1'b1;
      m_h2z[ch] = d;
   endtask

   task automatic host_ack(input int ch);
      @(negedge clk);
      ack[ch] = 1'b1;
      @(negedge clk);
      ack = '0;
      m_valid[ch] = 1'b0;
      m_zov[ch] = 1'b0;
   endtask

   function automatic void m_out(input int ch, input logic [7:0] d);
      if (m_valid[ch]) m_zov[ch] = 1'b1;
      m_valid[ch] = 1'b1;
      m_z2h[ch] = d;
   endfunction

   logic [7:0] rdv;
   logic       dirv;
   int         ch;
   logic [7:0] dv;

   initial begin
      m_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all("reset");
      chk("reset.dir", 64'(d_dir), 64'd1);

      // 1: OUT to channel 1, with latency check
      wr_start(BASE + 16'd2, 8'hA5);
      repeat (2) @(posedge clk);
      #1 chk("t1.lat2", 64'(valid), 64'h00);
      @(posedge clk);
      #1 chk("t1.lat3", 64'(valid), 64'h02);
      wr_end();
      m_out(1, 8'hA5);
      check_all("t1.out");
      host_ack(1);
      check_all("t1.ack");

      // 2: host load, status read, channel read
      host_load(3, 8'h5C);
      z80_in(STH, rdv, dirv);
      chk("t2.stat", 64'(rdv), 64'h08);
      chk("t2.statdir", 64'(dirv), 64'd0);
      check_all("t2.afterstat");
      z80_in(BASE + 16'd6, rdv, dirv);
      chk("t2.data", 64'(rdv), 64'h5C);
      m_full[3] = 1'b0;
      check_all("t2.clr");

      // 3: overrun on channel 0
      z80_out(BASE, 8'h11);
      m_out(0, 8'h11);
      z80_out(BASE, 8'h22);
      m_out(0, 8'h22);
      check_all("t3.ovr");
      z80_in(STZ, rdv, dirv);
      chk("t3.stat", 64'(rdv), 64'(m_valid));
      host_ack(0);
      check_all("t3.ack");

      // 4a: load and read-clear of channel 2 in the same clock
      host_load(2, 8'h33);
      in_start(BASE + 16'd4, rdv, dirv);
      chk("t4.rd", 64'(rdv), 64'h33);
      rd = 1'b1; iorq = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      h2z_flat[23:16] = 8'h77;
      load[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load = '0;
      repeat (3) @(negedge clk);
      m_hov[2] = 1'b1;
      m_h2z[2] = 8'h77;
      check_all("t4.ldwin");
      z80_in(BASE + 16'd4, rdv, dirv);
      chk("t4.newbyte", 64'(rdv), 64'h77);
      m_full[2] = 1'b0;

      // 4b: ack and Z80 write of channel 4 in the same clock
      z80_out(BASE + 16'd8, 8'h10);
      m_out(4, 8'h10);
      wr_start(BASE + 16'd8, 8'h99);
      repeat (2) @(posedge clk);
      @(negedge clk);
      ack[4] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ack = '0;
      wr_end();
      m_valid[4] = 1'b1;
      m_zov[4] = 1'b0;
      m_z2h[4] = 8'h99;
      check_all("t4.wrwin");

      // 6: undecoded port
      z80_in(BASE + 16'd16, rdv, dirv);
      chk("t6.dir", 64'(dirv), 64'd1);
      check_all("t6.noflag");

      // 5: ROM shadow paging
      @(negedge clk);
      a = 16'h0000; m1 = 1'b0; mreq = 1'b0; rd = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("t5.lat2", 64'(romcs), 64'd1);
      @(posedge clk);
      #1 chk("t5.trap", 64'(romcs), 64'd0);
      @(negedge clk);
      rd = 1'b1; m1 = 1'b1; mreq = 1'b1;
      repeat (4) @(negedge clk);
      m_romcs = 1'b0;
      z80_out(MAP, 8'h00);
      m_romcs = 1'b1;
      check_all("t5.out");
      z80_in(MAP, rdv, dirv);
      m_romcs = 1'b0;
      check_all("t5.in");
      do_reset();
      @(negedge clk);
      check_all("t5.rst");

      // randomised traffic
      for (int k = 0; k < 60; k++) begin
         ch = int'($urandom_range(0, 7));
         dv = 8'($urandom);
         case ($urandom_range(0, 4))
            0: begin
               z80_out(BASE + 16'(2 * ch), dv);
               m_out(ch, dv);
            end
            1: begin
               z80_in(BASE + 16'(2 * ch), rdv, dirv);
               chk("rnd.in", 64'(rdv), 64'(m_h2z[ch]));
               m_full[ch] = 1'b0;
            end
            2: host_load(ch, dv);
            3: host_ack(ch);
            default: begin
               z80_in(STH, rdv, dirv);
               chk("rnd.sth", 64'(rdv), 64'(m_full));
               z80_in(STZ, rdv, dirv);
               chk("rnd.stz", 64'(rdv), 64'(m_valid));
            end
         endcase
         check_all("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
